// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Digit slot indices within the 24-bit digit bus (slot i occupies [4i+3:4i]).
  localparam int SEC_U = 0;
  localparam int SEC_T = 1;
  localparam int MIN_U = 2;
  localparam int MIN_T = 3;
  localparam int HR_U  = 4;
  localparam int HR_T  = 5;

  localparam bcd_t TENS_MAX  = 4'd5;
  localparam bcd_t UNITS_MAX = 4'd9;

  // Largest legal value of a digit slot.
  function automatic bcd_t slot_max(input int slot);
    return (slot == SEC_T || slot == MIN_T) ? TENS_MAX : UNITS_MAX;
  endfunction

endpackage

// File: rtl/timer_ctrl_tick_prescaler.sv
// Free-running prescaler that emits one tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 while enabled; hold when disabled; clr forces zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Six-digit BCD timer sequencer: start/pause/clear/load control, up/down count.
//
//  state | meaning
//  IDLE  | stopped; load and clear accepted, start begins a run
//  RUN   | counting one second per prescaler tick
//  PAUSE | frozen; prescaler position held for resume
//  DONE  | down-count reached zero; waits for clear
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_val,
  input  logic        mode,
  output logic [23:0] digits,
  output logic        running,
  output logic        done
);

  state_t      state;
  logic        mode_q;
  logic        tick;
  logic        pre_en;
  logic        pre_clr;
  logic [23:0] stepped;

  // Step by one second with full carry (up) or borrow (down) across all slots.
  function automatic logic [23:0] bcd_step(input logic [23:0] d, input logic down);
    logic [23:0] r;
    logic        c;
    bcd_t        v;
    r = d;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = d[i*4 +: 4];
      if (c) begin
        if (!down) begin
          if (v >= slot_max(i)) v = 4'd0;
          else begin v = v + 4'd1; c = 1'b0; end
        end else begin
          if (v == 4'd0) v = slot_max(i);
          else begin v = v - 4'd1; c = 1'b0; end
        end
      end
      r[i*4 +: 4] = v;
    end
    return r;
  endfunction

  // Zero any preset digit that is out of range for its slot.
  function automatic logic [23:0] bcd_sanitize(input logic [23:0] d);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = (d[i*4 +: 4] > slot_max(i)) ? 4'd0 : d[i*4 +: 4];
    end
    return r;
  endfunction

  // Prescaler runs only in RUN (including the edge that leaves for PAUSE,
  // so a coincident tick still lands and the held count wraps to 0).
  assign pre_en  = (state == RUN);
  assign pre_clr = clear || (state == IDLE) || (state == DONE);
  assign stepped = bcd_step(digits, mode_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      digits  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            digits <= '0;
          end else if (load) begin
            digits <= bcd_sanitize(load_val);
          end else if (pause) begin
            // no effect in IDLE, but still outranks start
          end else if (start) begin
            mode_q <= mode;
            if (mode && digits == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clear) begin
            state   <= IDLE;
            digits  <= '0;
            running <= 1'b0;
          end else begin
            if (tick) digits <= stepped;
            if (tick && mode_q && stepped == '0) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (clear) begin
            state  <= IDLE;
            digits <= '0;
          end else if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          digits <= '0;
          if (clear) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          digits  <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=4.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_val = '0;
  logic        mode = 1'b0;
  logic [23:0] digits;
  logic        running;
  logic        done;

  int total = 0;
  int bad   = 0;

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .digits   (digits),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All helpers leave time at #1 after the most recent rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m;
    cycles(1);
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    cycles(1);
    pause = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1; load_val = v;
    cycles(1);
    load = 1'b0; load_val = '0;
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // count up: first tick 4 cycles after acceptance, 60 ticks -> 00:01:00
    do_start(1'b0);
    check("up_running", 32'(running), 32'h1);
    cycles(3);
    check("up_pre_tick", 32'(digits), 32'h0);
    cycles(1);
    check("up_first_tick", 32'(digits), 32'h000001);
    cycles(59 * 4);
    check("up_60_ticks", 32'(digits), 32'h000100);
    check("up_60_running", 32'(running), 32'h1);

    // full wrap 99:59:59 -> 00:00:00 stays in RUN
    do_clear();
    check("clr_running", 32'(running), 32'h0);
    do_load(24'h995959);
    check("load_max", 32'(digits), 32'h995959);
    do_start(1'b0);
    cycles(3);
    check("wrap_pre", 32'(digits), 32'h995959);
    cycles(1);
    check("wrap_digits", 32'(digits), 32'h000000);
    check("wrap_running", 32'(running), 32'h1);

    // count down 2 -> 0 enters DONE; DONE ignores start
    do_clear();
    do_load(24'h000002);
    do_start(1'b1);
    cycles(4);
    check("down_one", 32'(digits), 32'h000001);
    check("down_one_run", 32'(running), 32'h1);
    cycles(4);
    check("down_zero", 32'(digits), 32'h000000);
    check("down_done", 32'(done), 32'h1);
    check("down_running", 32'(running), 32'h0);
    for (int i = 0; i < 10; i++) begin
      do_start(1'b0);
      cycles(1);
    end
    check("done_hold_digits", 32'(digits), 32'h000000);
    check("done_hold_done", 32'(done), 32'h1);
    check("done_hold_run", 32'(running), 32'h0);
    do_clear();
    check("done_clr_done", 32'(done), 32'h0);
    check("done_clr_run", 32'(running), 32'h0);

    // pause holds prescaler position; resume ticks 2 cycles later
    do_start(1'b0);
    cycles(1);
    do_pause();
    check("pause_running", 32'(running), 32'h0);
    cycles(10);
    check("pause_frozen", 32'(digits), 32'h0);
    do_start(1'b0);
    check("resume_running", 32'(running), 32'h1);
    cycles(1);
    check("resume_pre", 32'(digits), 32'h0);
    cycles(1);
    check("resume_tick", 32'(digits), 32'h000001);

    // pause coincident with tick: tick lands, prescaler restarts at 0
    cycles(3);
    do_pause();
    check("tickpause_digits", 32'(digits), 32'h000002);
    check("tickpause_run", 32'(running), 32'h0);
    do_start(1'b0);
    cycles(3);
    check("tickpause_pre", 32'(digits), 32'h000002);
    cycles(1);
    check("tickpause_next", 32'(digits), 32'h000003);

    // sanitised load; clear beats start in RUN
    do_clear();
    do_load(24'h0A6F12);
    check("load_sanitize", 32'(digits), 32'h000012);
    do_start(1'b0);
    clear = 1'b1; start = 1'b1;
    cycles(1);
    clear = 1'b0; start = 1'b0;
    check("clrstart_digits", 32'(digits), 32'h0);
    check("clrstart_running", 32'(running), 32'h0);

    // clear coincident with tick: clear wins
    do_start(1'b0);
    cycles(3);
    do_clear();
    check("clrtick_digits", 32'(digits), 32'h0);
    check("clrtick_running", 32'(running), 32'h0);

    // rst mid-run with start high
    do_start(1'b0);
    cycles(5);
    check("prerst_digits", 32'(digits), 32'h000001);
    rst = 1'b1; start = 1'b1;
    cycles(1);
    rst = 1'b0; start = 1'b0;
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_running", 32'(running), 32'h0);
    check("midrst_done", 32'(done), 32'h0);

    // down start from zero goes straight to DONE
    do_start(1'b1);
    check("zero_down_done", 32'(done), 32'h1);
    check("zero_down_run", 32'(running), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
